// File: rtl/unidade_controle_rodadas.sv
// Round controller for the sequence-memory game: a Moore FSM that drives the
// address counter (E), round-limit counter (L) and play register (R), plus a
// per-play inactivity timer.
//
//  state          | code | meaning
//  inicial        | 0    | idle, waiting for jogar
//  preparacao     | 1    | clear E, L and R for a new game
//  inicia_rodada  | 2    | clear E to replay the sequence from address 0
//  espera_jogada  | 3    | wait for a press, timer running
//  registra       | 4    | load the pressed buttons into R
//  comparacao     | 5    | R now valid; decide the outcome of this play
//  proxima_jogada | 6    | advance E to the next address of this round
//  proxima_rodada | 7    | advance L, one more play in the next round
//  fim_acertou    | A    | game won, hold until jogar
//  fim_timeout    | D    | game lost by inactivity, hold until jogar
//  fim_errou      | E    | game lost by wrong play, hold until jogar
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       igualJ,
  input  logic       enderecoIgualL,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CICLOS - 1);

  localparam logic [3:0] S_INICIAL        = 4'h0;
  localparam logic [3:0] S_PREPARACAO     = 4'h1;
  localparam logic [3:0] S_INICIA_RODADA  = 4'h2;
  localparam logic [3:0] S_ESPERA_JOGADA  = 4'h3;
  localparam logic [3:0] S_REGISTRA       = 4'h4;
  localparam logic [3:0] S_COMPARACAO     = 4'h5;
  localparam logic [3:0] S_PROXIMA_JOGADA = 4'h6;
  localparam logic [3:0] S_PROXIMA_RODADA = 4'h7;
  localparam logic [3:0] S_FIM_ACERTOU    = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT    = 4'hD;
  localparam logic [3:0] S_FIM_ERROU      = 4'hE;

  logic [3:0]    estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timer_fim;

  assign timer_fim = (timer_q == TIMER_LAST);

  // State and timer registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= S_INICIAL;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end

  // Timer counts only while waiting for a play; saturates so it can never wrap
  always_comb begin
    timer_d = '0;
    if (estado_q == S_ESPERA_JOGADA && !timer_fim) timer_d = timer_q + TW'(1);
    else if (estado_q == S_ESPERA_JOGADA)          timer_d = timer_q;
  end

  // Next-state logic; a press in the last timer cycle still counts as a play
  always_comb begin
    estado_d = S_INICIAL;
    case (estado_q)
      S_INICIAL:        estado_d = jogar ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO:     estado_d = S_INICIA_RODADA;
      S_INICIA_RODADA:  estado_d = S_ESPERA_JOGADA;
      S_ESPERA_JOGADA: begin
        if (jogada_feita)   estado_d = S_REGISTRA;
        else if (timer_fim) estado_d = S_FIM_TIMEOUT;
        else                estado_d = S_ESPERA_JOGADA;
      end
      S_REGISTRA:       estado_d = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!igualJ)                    estado_d = S_FIM_ERROU;
        else if (enderecoIgualL && fimL) estado_d = S_FIM_ACERTOU;
        else if (enderecoIgualL)        estado_d = S_PROXIMA_RODADA;
        else                            estado_d = S_PROXIMA_JOGADA;
      end
      S_PROXIMA_JOGADA: estado_d = S_ESPERA_JOGADA;
      S_PROXIMA_RODADA: estado_d = S_INICIA_RODADA;
      S_FIM_ACERTOU:    estado_d = jogar ? S_PREPARACAO : S_FIM_ACERTOU;
      S_FIM_ERROU:      estado_d = jogar ? S_PREPARACAO : S_FIM_ERROU;
      S_FIM_TIMEOUT:    estado_d = jogar ? S_PREPARACAO : S_FIM_TIMEOUT;
      default:          estado_d = S_INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraL      = 1'b0;
    contaL     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    case (estado_q)
      S_PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      S_INICIA_RODADA:  zeraE = 1'b1;
      S_REGISTRA:       registraR = 1'b1;
      S_PROXIMA_JOGADA: contaE = 1'b1;
      S_PROXIMA_RODADA: contaL = 1'b1;
      S_FIM_ACERTOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
      end
      S_FIM_ERROU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
      end
      S_FIM_TIMEOUT: begin
        perdeu     = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round controller: a small behavioural datapath (E, L, R and a
// four-entry memory) answers the FSM, and a scoreboard holds the expected
// outcome of each play until the controller reaches its decision state.
module tb_unidade_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset, jogar, jogada_feita;
  logic       igualJ, enderecoIgualL, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       ganhou, perdeu, pronto, db_timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem [0:3];
  logic [1:0] e_m = '0;
  logic [1:0] l_m = '0;
  logic [3:0] r_m = '0;
  logic [3:0] botoes = '0;
  int         contaL_pulsos = 0;
  logic [3:0] exp_q [$];

  unidade_controle_rodadas #(.TIMEOUT_CICLOS(3000)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
    .igualJ(igualJ), .enderecoIgualL(enderecoIgualL), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .ganhou(ganhou), .perdeu(perdeu),
    .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // behavioural datapath driven by the controller's commands
  always @(posedge clock) begin
    if (zeraE) e_m <= '0;
    else if (contaE) e_m <= e_m + 2'd1;
    if (zeraL) l_m <= '0;
    else if (contaL) l_m <= l_m + 2'd1;
    if (zeraR) r_m <= '0;
    else if (registraR) r_m <= botoes;
  end

  assign igualJ         = (r_m == mem[e_m]);
  assign enderecoIgualL = (e_m == l_m);
  assign fimL           = (l_m == 2'd3);

  always @(negedge clock) if (contaL) contaL_pulsos <= contaL_pulsos + 1;

  function automatic logic [9:0] saidas();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
            ganhou, perdeu, pronto, db_timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_state", {28'd0, db_estado}, {28'd0, s});
  endtask

  // one press: wait for espera_jogada, idle 'atraso' cycles, press 'v'
  task automatic play(input logic [3:0] v, input logic [3:0] exp_dec, input int atraso);
    logic [3:0] e;
    wait_state(4'h3, 50);
    repeat (atraso) @(negedge clock);
    botoes = v;
    jogada_feita = 1'b1;
    exp_q.push_back(exp_dec);
    @(negedge clock);
    jogada_feita = 1'b0;
    chk("registra", {28'd0, db_estado}, 32'h4);
    @(negedge clock);
    chk("comparacao", {28'd0, db_estado}, 32'h5);
    @(negedge clock);
    if (exp_q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      chk("decisao", {28'd0, db_estado}, {28'd0, e});
    end
  endtask

  // one round with L=r; wrong_j selects the play that gets a wrong value
  task automatic run_round(input int r, input int wrong_j, output logic perdeu_m);
    logic [3:0] v, d;
    perdeu_m = 1'b0;
    for (int j = 0; j <= r; j++) begin
      if (j == wrong_j) begin
        v = mem[j] ^ 4'hF;
        d = 4'hE;
      end else begin
        v = mem[j];
        d = (j != r) ? 4'h6 : ((r == 3) ? 4'hA : 4'h7);
      end
      play(v, d, 1 + (j % 3));
      if (j == wrong_j) begin
        perdeu_m = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] est_exp [0:4];
    int         sobe_e, sobe_l, sobe_r, n, pulsos0;
    logic       pe, pl, pr, lost;

    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
    est_exp[0] = 4'h1; est_exp[1] = 4'h2; est_exp[2] = 4'h3;
    est_exp[3] = 4'h3; est_exp[4] = 4'h3;

    // 1: reset then idle
    reset = 1'b1; jogar = 1'b0; jogada_feita = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_estado", {28'd0, db_estado}, 32'h0);
    chk("idle_saidas", {22'd0, saidas()}, 32'h0);

    // 2: jogar held high for 5 cycles
    jogar = 1'b1;
    sobe_e = 0; sobe_l = 0; sobe_r = 0;
    pe = 1'b0; pl = 1'b0; pr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("start_seq", {28'd0, db_estado}, {28'd0, est_exp[i]});
      if (zeraE && !pe) sobe_e++;
      if (zeraL && !pl) sobe_l++;
      if (zeraR && !pr) sobe_r++;
      pe = zeraE; pl = zeraL; pr = zeraR;
    end
    jogar = 1'b0;
    chk("zeraE_pulsos", sobe_e, 1);
    chk("zeraL_pulsos", sobe_l, 1);
    chk("zeraR_pulsos", sobe_r, 1);

    // 3: full winning game
    pulsos0 = contaL_pulsos;
    for (int r = 0; r < 4; r++) run_round(r, 99, lost);
    repeat (3) @(negedge clock);
    chk("win_estado", {28'd0, db_estado}, 32'hA);
    chk("win_ganhou", {31'd0, ganhou}, 32'd1);
    chk("win_pronto", {31'd0, pronto}, 32'd1);
    chk("win_perdeu", {31'd0, perdeu}, 32'd0);
    chk("win_contaL", contaL_pulsos - pulsos0, 3);

    // 4: restart, wrong second play in round L=2
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("restart_win", {28'd0, db_estado}, 32'h1);
    for (int r = 0; r < 3; r++) begin
      run_round(r, (r == 2) ? 1 : 99, lost);
      if (lost) break;
    end
    repeat (2) @(negedge clock);
    chk("err_estado", {28'd0, db_estado}, 32'hE);
    chk("err_saidas", {22'd0, saidas()}, 32'b0000000110);
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("restart_err", {28'd0, db_estado}, 32'h1);

    // 5a: no press -> timeout after exactly 3000 cycles in espera_jogada
    wait_state(4'h3, 10);
    n = 1;
    while (n < 4000) begin
      @(negedge clock);
      if (db_estado !== 4'h3) break;
      n++;
    end
    chk("timeout_ciclos", n, 3000);
    chk("timeout_estado", {28'd0, db_estado}, 32'hD);
    chk("timeout_saidas", {22'd0, saidas()}, 32'b0000000111);
    repeat (3) @(negedge clock);
    chk("timeout_hold", {28'd0, db_estado}, 32'hD);

    // 5b: press in the last timer cycle still registers
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("restart_to", {28'd0, db_estado}, 32'h1);
    play(mem[0], 4'h7, 2999);

    // 6: reset mid-wait with timer at 1500
    wait_state(4'h3, 10);
    repeat (1500) @(negedge clock);
    chk("timer_1500", {20'd0, dut.timer_q}, 32'd1500);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_estado", {28'd0, db_estado}, 32'h0);
    chk("rst_timer", {20'd0, dut.timer_q}, 32'd0);
    chk("rst_saidas", {22'd0, saidas()}, 32'h0);
    repeat (3) @(negedge clock);
    chk("rst_fica", {28'd0, db_estado}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
